// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: loads a length-prefixed byte image into instruction memory, then releases and clocks the CPU.
// Latency: a word is written the cycle after its 4th byte is accepted; RUN is entered on that same edge for the last word.
// Backpressure: rx_ready is high only in HDR0/HDR1/DATA; the CPU is paced by cpu_ce (free run or single step).
module cpu_boot_ctrl (
  input  logic        clk,
  input  logic        resetN,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        load_req,
  input  logic        run_req,
  input  logic        step_mode,
  input  logic        step_btn,
  output logic        imem_we,
  output logic [8:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_resetN,
  output logic        cpu_ce,
  output logic        busy,
  output logic        err,
  output logic [9:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_RUN, S_ERR
  } state_t;

  state_t      state, next_state;
  logic [7:0]  n_lo;        // low byte of the word count from HDR0
  logic [9:0]  n_words;     // word count of the load in progress (1..512)
  logic [1:0]  byte_idx;    // byte position inside the current word
  logic [23:0] partial;     // first three bytes of the current word
  logic        step_prev;   // previous step_btn level for edge detection

  logic        accept;
  logic [15:0] hdr_n;
  logic        word_done;
  logic        last_word;
  logic        hdr_bad;
  logic        step_edge;

  assign accept    = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, n_lo};
  assign hdr_bad   = (hdr_n == 16'd0) || (hdr_n > 16'd512);
  assign word_done = accept && (state == S_DATA) && (byte_idx == 2'd3);
  // words_loaded doubles as the index of the word being assembled
  assign last_word = (words_loaded == n_words - 10'd1);
  assign step_edge = step_btn && !step_prev;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state selection; requests are only honoured outside the load states
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (load_req)     next_state = S_HDR0;
        else if (run_req) next_state = S_RUN;
      end
      S_HDR0: if (accept) next_state = S_HDR1;
      S_HDR1: if (accept) next_state = hdr_bad ? S_ERR : S_DATA;
      S_DATA: if (word_done && last_word) next_state = S_RUN;
      S_RUN:  if (load_req) next_state = S_HDR0;
      S_ERR:  if (load_req) next_state = S_HDR0;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs derived from the state being entered, plus the load datapath
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rx_ready     <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      cpu_resetN   <= 1'b0;
      cpu_ce       <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      n_lo         <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      partial      <= '0;
      step_prev    <= 1'b0;
    end else begin
      rx_ready   <= (next_state == S_HDR0) || (next_state == S_HDR1) || (next_state == S_DATA);
      busy       <= (next_state == S_HDR0) || (next_state == S_HDR1) || (next_state == S_DATA);
      err        <= (next_state == S_ERR);
      cpu_resetN <= (next_state == S_RUN);
      // the RUN entry cycle never enables the core; the edge detector is not queued
      cpu_ce     <= (state == S_RUN) && (next_state == S_RUN) && (!step_mode || step_edge);
      step_prev  <= step_btn;
      imem_we    <= word_done;

      if (state == S_HDR0 && accept) n_lo <= rx_data;

      if (state == S_HDR1 && accept && !hdr_bad) begin
        n_words      <= hdr_n[9:0];
        words_loaded <= '0;
        byte_idx     <= '0;
      end

      if (state == S_DATA && accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: partial[7:0]   <= rx_data;
          2'd1: partial[15:8]  <= rx_data;
          2'd2: partial[23:16] <= rx_data;
          default: begin
            imem_addr    <= words_loaded[8:0];
            imem_wdata   <= {rx_data, partial};
            words_loaded <= words_loaded + 10'd1;
          end
        endcase
      end
    end
  end

endmodule
